// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritized, edge-triggered interrupt controller with PC redirect
// and a return stack that holds the interrupted PC and level.
// Optional feature: define IRQ_CTRL_NEST_EN to allow a higher channel to preempt a
// running handler. The stack is then N_IRQ deep. Without the macro, only one level
// of service is possible and the stack is 1 deep.
module irq_ctrl #(
    parameter int              N_IRQ      = 3,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(32'h0000_0100),
    parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(32'h0000_0040)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic [N_IRQ-1:0]  irq_mask,
    input  logic [PC_W-1:0]   pc_next,
    input  logic              cpu_en,
    input  logic              ret_in,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [N_IRQ:0]    save_lvl,
    output logic [N_IRQ:0]    restore_lvl,
    output logic [N_IRQ-1:0]  running,
    output logic [3:0]        cur_lvl,
    output logic              ret_err
);

    localparam int LVL_W = N_IRQ + 1;

    typedef enum logic [1:0] {RUN, ENTER, EXIT} state_t;

    logic lvl_ok;

`ifdef IRQ_CTRL_NEST_EN
    localparam int DEPTH = N_IRQ;
    assign lvl_ok = 1'b1;
`else
    localparam int DEPTH = 1;
    assign lvl_ok = (cur_lvl == 4'd0);
`endif

    state_t           state;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] pend_now;
    logic [2:0]       win_idx;
    logic             win_vld;
    logic [2:0]       win_reg;

    // Return stack: entry 0 is the top. Push shifts down and pop shifts up.
    logic [PC_W-1:0]  stk_pc  [DEPTH];
    logic [3:0]       stk_lvl [DEPTH];

    function automatic logic [N_IRQ:0] lvl_onehot(input logic [3:0] lvl);
        return LVL_W'(1) << lvl;
    endfunction

    function automatic logic [N_IRQ-1:0] ch_onehot(input logic [2:0] ch);
        return N_IRQ'(1) << ch;
    endfunction

    function automatic logic [PC_W-1:0] vec_addr(input logic [2:0] ch);
        return VEC_BASE + PC_W'(ch) * VEC_STRIDE;
    endfunction

    assign edge_det = irq_in & ~irq_prev;
    assign pend_now = pending | edge_det;

    // Highest eligible channel wins. Edges arriving this cycle count, so entry happens one cycle after the edge.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 3'd0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (pend_now[k] && irq_mask[k] && (4'(k + 1) > cur_lvl) && lvl_ok) begin
                win_vld = 1'b1;
                win_idx = 3'(k);
            end
        end
    end

    // Control FSM with registered redirect outputs. Edge history reloads on reset so no spurious edge appears.
    always_ff @(posedge clk) begin
        irq_prev <= irq_in;
        if (clr) begin
            state       <= RUN;
            pending     <= '0;
            running     <= '0;
            cur_lvl     <= 4'd0;
            ret_err     <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            save_lvl    <= '0;
            restore_lvl <= '0;
            win_reg     <= 3'd0;
        end else begin
            pending <= pend_now;
            case (state)
                RUN: begin
                    if (ret_in && cur_lvl != 4'd0) begin
                        state       <= EXIT;
                        redirect    <= 1'b1;
                        redirect_pc <= stk_pc[0];
                        restore_lvl <= lvl_onehot(stk_lvl[0]);
                    end else begin
                        if (ret_in) begin
                            ret_err <= 1'b1;
                        end
                        if (win_vld) begin
                            state       <= ENTER;
                            win_reg     <= win_idx;
                            redirect    <= 1'b1;
                            redirect_pc <= vec_addr(win_idx);
                            save_lvl    <= lvl_onehot(cur_lvl);
                        end
                    end
                end
                ENTER: begin
                    if (cpu_en) begin
                        pending  <= pend_now & ~ch_onehot(win_reg);
                        running  <= running | ch_onehot(win_reg);
                        cur_lvl  <= {1'b0, win_reg} + 4'd1;
                        state    <= RUN;
                        redirect <= 1'b0;
                        save_lvl <= '0;
                    end
                end
                EXIT: begin
                    if (cpu_en) begin
                        running     <= running & ~ch_onehot(3'(cur_lvl - 4'd1));
                        cur_lvl     <= stk_lvl[0];
                        state       <= RUN;
                        redirect    <= 1'b0;
                        restore_lvl <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Stack push on ENTER completion and pop on EXIT completion. The data is not reset because cur_lvl gates its use.
    always_ff @(posedge clk) begin
        if (!clr && state == ENTER && cpu_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stk_pc[i]  <= stk_pc[i-1];
                stk_lvl[i] <= stk_lvl[i-1];
            end
            stk_pc[0]  <= pc_next;
            stk_lvl[0] <= cur_lvl;
        end else if (!clr && state == EXIT && cpu_en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                stk_pc[i]  <= stk_pc[i+1];
                stk_lvl[i] <= stk_lvl[i+1];
            end
        end
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 3: number of interrupt channels, 1..8.
REQ-002 Parameter PC_W, default 32: PC width.
REQ-003 Parameter VEC_BASE, default 32'h0000_0100: vector of channel 0.
REQ-004 Parameter VEC_STRIDE, default 32'h0000_0040: spacing between channel vectors.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 clr  in  1  reset, synchronous, active-high.
REQ-007 irq_in  in  N_IRQ  raw interrupt requests, rising-edge sensitive.
REQ-008 irq_mask  in  N_IRQ  per-channel enable, 1 = enabled.
REQ-009 pc_next  in  PC_W  PC the CPU would load this cycle.
REQ-010 cpu_en  in  1  CPU PC-update enable; redirect consumed only when 1.
REQ-011 ret_in  in  1  one-cycle pulse, decoder detected return-from-interrupt.
REQ-012 redirect  out  1  CPU loads redirect_pc instead of pc_next.
REQ-013 redirect_pc  out  PC_W  vector on entry, saved PC on exit.
REQ-014 save_lvl  out  N_IRQ+1  one-hot register-bank backup strobe, level being left.
REQ-015 restore_lvl  out  N_IRQ+1  one-hot register-bank restore strobe, level being resumed.
REQ-016 running  out  N_IRQ  per-channel in-service flags.
REQ-017 cur_lvl  out  4  current level; 0 = user, k+1 = channel k.
REQ-018 ret_err  out  1  sticky: ret_in received at level 0.

Function
REQ-019 Edge detect: pending[k] SHALL set on the cycle irq_in[k] is 1 after being 0 the previous cycle; pending stays set regardless of mask.
REQ-020 Priority: higher channel index SHALL win; channel k eligible when pending[k] & irq_mask[k] & (k+1 > cur_lvl).
REQ-021 FSM states: RUN, ENTER, EXIT; reset state RUN.
REQ-022 RUN -> EXIT when ret_in=1 and cur_lvl>0; ret_in has priority over an eligible channel in the same cycle.
REQ-023 RUN -> ENTER when an eligible channel exists and no EXIT is taken; winning index latched.
REQ-024 In ENTER: redirect=1, redirect_pc = VEC_BASE + k*VEC_STRIDE (PC_W bits, wrap-around truncation), save_lvl = onehot(cur_lvl).
REQ-025 ENTER completes on the first cycle with cpu_en=1: push pc_next and cur_lvl onto stack, cur_lvl <= k+1, running[k] <= 1, pending[k] <= 0, state <= RUN; outputs held while cpu_en=0.
REQ-026 In EXIT: redirect=1, redirect_pc = stack top PC, restore_lvl = onehot(stack top level).
REQ-027 EXIT completes on first cycle with cpu_en=1: running[cur_lvl-1] <= 0, cur_lvl <= stacked level, pop, state <= RUN.
REQ-028 Latency: irq edge at cycle t -> redirect high at cycle t+1 (if eligible and RUN).
REQ-029 Stack depth N_IRQ; overflow impossible by strict priority; ret_in in ENTER/EXIT SHALL be ignored.
REQ-030 ret_in at cur_lvl=0 in RUN SHALL set ret_err, no state change.
REQ-031 A new edge on a channel already pending or running SHALL be merged (no counting).
REQ-032 redirect, save_lvl, restore_lvl SHALL be 0 in RUN.

Reset
REQ-033 clr=1 at a rising edge SHALL force: state RUN, stack empty, pending 0, running 0, cur_lvl 0, ret_err 0, all strobes 0, redirect 0, redirect_pc 0, edge-history = current irq_in (no spurious edge); overrides an in-progress ENTER/EXIT.

Configuration
REQ-034 Macro IRQ_CTRL_NEST_EN defined: preemption per REQ-020, stack depth N_IRQ.
REQ-035 Macro IRQ_CTRL_NEST_EN undefined: eligibility additionally requires cur_lvl=0; stack depth 1; higher channels wait pending until return.

Verification
REQ-036 Reset, irq_in[0] 0->1, mask 3'b111, cpu_en=1, pc_next=0x40 -> next cycle redirect=1, redirect_pc=0x100, save_lvl=4'b0001; then cur_lvl=1, running=3'b001.
REQ-037 In channel 0 service, irq_in[2] rises -> redirect_pc=0x180, save_lvl=4'b0010; ret_in -> redirect_pc = stacked PC, restore_lvl=4'b0010, cur_lvl=1 (nest build); without macro, channel 2 waits until return to level 0.
REQ-038 Channels 1 and 2 rise same cycle -> channel 2 taken first; channel 1 taken after channel 2 returns, vector 0x140.
REQ-039 ENTER with cpu_en=0 for 3 cycles -> redirect and redirect_pc held stable, no push until cpu_en=1.
REQ-040 ret_in at level 0 -> ret_err=1, redirect=0; clr mid-ENTER -> all outputs 0 next cycle.
